// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/ME main-memory port arbiter.
// Optional misaligned-access checking is enabled with MEM_ALIGN_CHECK_EN.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_ME = 1'b1
  } owner_t;

  localparam int EDIT_SERIAL_W = 65;
  localparam int ES_WE         = 64;
  localparam int ES_ADDR_LSB   = 32;
  localparam int CNT_W         = 4;
  localparam int STREAK_W      = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Stage-side and memory-side signals of the main-memory port arbiter.
// The arbiter uses the slave modport; the pipeline/memory side uses master.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        me_req;
  logic        me_we;
  logic [31:0] me_addr;
  logic [31:0] me_wdata;
  logic [31:0] me_rdata;
  logic        me_ready;
  logic        me_err;
  logic [31:0] mem_addr;
  logic [64:0] mem_edit_serial;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_me;

  modport master (
    output if_req, if_addr, me_req, me_we, me_addr, me_wdata, mem_rdata,
    input  if_rdata, if_ready, me_rdata, me_ready, me_err,
           mem_addr, mem_edit_serial, stall_if, stall_me
  );

  modport slave (
    input  if_req, if_addr, me_req, me_we, me_addr, me_wdata, mem_rdata,
    output if_rdata, if_ready, me_rdata, me_ready, me_err,
           mem_addr, mem_edit_serial, stall_if, stall_me
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational IF/ME pick: ME wins unless IF has waited out MAX_DATA_STREAK
// back-to-back ME grants.
module mem_arb_pick
  import mem_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                if_req_i,
  input  logic                me_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  output logic                grant_valid_o,
  output owner_t              grant_owner_o
);

  logic if_starved;

  assign if_starved = if_req_i && (streak_i == STREAK_W'(MAX_DATA_STREAK));

  always_comb begin
    grant_valid_o = if_req_i | me_req_i;
    grant_owner_o = OWN_IF;
    if (me_req_i && !if_starved) begin
      grant_owner_o = OWN_ME;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port MainMemory sequencer shared by IF and ME: IDLE/BUSY/DONE FSM,
// starvation-guarded arbitration, registered read data and ready pulses.
// Optional macro MEM_ALIGN_CHECK_EN flags and suppresses misaligned ME accesses.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic              Clock,
  input logic              RESET,
  mem_port_arbiter_if.slave bus
);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STREAK_W-1:0] streak_q;
  owner_t              owner_q;
  logic [29:0]         addr_q;
  logic [31:0]         wdata_q;
  logic                es_we_q;
  logic                err_q;
  logic [31:0]         if_rdata_q;
  logic [31:0]         me_rdata_q;
  logic                if_ready_q;
  logic                me_ready_q;
  logic                me_err_q;

  logic   grant_valid;
  owner_t grant_owner;
  logic   me_misaligned;
  logic   unused_addr_bits;

  mem_arb_pick #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_pick (
    .if_req_i     (bus.if_req),
    .me_req_i     (bus.me_req),
    .streak_i     (streak_q),
    .grant_valid_o(grant_valid),
    .grant_owner_o(grant_owner)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign me_misaligned = |bus.me_addr[1:0];
`else
  assign me_misaligned = 1'b0;
`endif

  // Byte-offset bits only matter to the optional alignment check.
  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.me_addr[1:0]};

  always_ff @(posedge Clock) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      es_we_q    <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      me_rdata_q <= '0;
      if_ready_q <= 1'b0;
      me_ready_q <= 1'b0;
      me_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.if_req) begin
            streak_q <= '0;
          end
          if (grant_valid) begin
            state_q <= BUSY;
            cnt_q   <= CNT_W'(MEM_LATENCY - 1);
            owner_q <= grant_owner;
            if (grant_owner == OWN_ME) begin
              addr_q  <= bus.me_addr[31:2];
              wdata_q <= bus.me_wdata;
              es_we_q <= bus.me_we & ~me_misaligned;
              err_q   <= me_misaligned;
              if (bus.if_req && (streak_q != '1)) begin
                streak_q <= streak_q + 1'b1;
              end
            end else begin
              addr_q   <= bus.if_addr[31:2];
              wdata_q  <= '0;
              es_we_q  <= 1'b0;
              err_q    <= 1'b0;
              streak_q <= '0;
            end
          end
        end
        BUSY: begin
          // The write strobe is only ever live for the first BUSY cycle.
          es_we_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= DONE;
            if (owner_q == OWN_ME) begin
              me_rdata_q <= bus.mem_rdata;
              me_ready_q <= 1'b1;
              me_err_q   <= err_q;
            end else begin
              if_rdata_q <= bus.mem_rdata;
              if_ready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          if_ready_q <= 1'b0;
          me_ready_q <= 1'b0;
          me_err_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.mem_edit_serial                          = '0;
    bus.mem_edit_serial[ES_WE]                   = es_we_q;
    bus.mem_edit_serial[ES_WE-1:ES_ADDR_LSB]     = {2'b00, addr_q};
    bus.mem_edit_serial[ES_ADDR_LSB-1:0]         = wdata_q;
  end

  assign bus.mem_addr = {2'b00, addr_q};
  assign bus.if_rdata = if_rdata_q;
  assign bus.me_rdata = me_rdata_q;
  assign bus.if_ready = if_ready_q;
  assign bus.me_ready = me_ready_q;
  assign bus.me_err   = me_err_q;
  assign bus.stall_if = bus.if_req & ~if_ready_q;
  assign bus.stall_me = bus.me_req & ~me_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a combinational-read memory model.
// Expectations follow MEM_ALIGN_CHECK_EN when the build defines it.
module tb_mem_port_arbiter;

  localparam int ML  = 1;
  localparam int MDS = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    logic        is_me;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_word;
    int          exp_wpulse;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .MEM_LATENCY(ML),
    .MAX_DATA_STREAK(MDS)
  ) dut (
    .Clock(clk),
    .RESET(rst),
    .bus  (bus)
  );

  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          we_pulses = 0;

  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  always @(posedge clk) begin
    if (bus.mem_edit_serial[64]) begin
      mem[bus.mem_edit_serial[39:32]] <= bus.mem_edit_serial[31:0];
      we_pulses <= we_pulses + 1;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int cyc;
    int p0;
    logic rdy;
    @(negedge clk);
    p0 = we_pulses;
    if (v.is_me) begin
      bus.me_req = 1'b1; bus.me_we = v.we; bus.me_addr = v.addr; bus.me_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    @(posedge clk); #1;
    check($sformatf("v%0d mem_addr", idx), {33'b0, bus.mem_addr}, {33'b0, v.exp_word});
    check($sformatf("v%0d stall", idx), {64'b0, v.is_me ? bus.stall_me : bus.stall_if}, 65'd1);
    check($sformatf("v%0d es_we", idx), {64'b0, bus.mem_edit_serial[64]}, {64'b0, v.exp_wpulse == 1});
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      rdy = v.is_me ? bus.me_ready : bus.if_ready;
    end
    check($sformatf("v%0d latency", idx), 65'(cyc), 65'(ML));
    if (v.chk_rd) begin
      check($sformatf("v%0d rdata", idx), {33'b0, v.is_me ? bus.me_rdata : bus.if_rdata},
            {33'b0, v.exp_rdata});
    end
    check($sformatf("v%0d me_err", idx), {64'b0, bus.me_err}, {64'b0, v.exp_err});
    check($sformatf("v%0d other_ready", idx), {64'b0, v.is_me ? bus.if_ready : bus.me_ready}, 65'd0);
    bus.me_req = 1'b0; bus.if_req = 1'b0; bus.me_we = 1'b0;
    @(posedge clk); #1;
    check($sformatf("v%0d ready_drop", idx), {63'b0, bus.me_ready, bus.if_ready}, 65'd0);
    check($sformatf("v%0d we_pulses", idx), 65'(we_pulses - p0), 65'(v.exp_wpulse));
  endtask

  vec_t vecs[9];

  initial begin
    int  cyc;
    int  p0;
    logic [9:0] order;
    logic [9:0] exp_order;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.me_req = 1'b0; bus.me_we = 1'b0; bus.me_addr = '0; bus.me_wdata = '0;

    vecs[0] = '{1'b1, 1'b0, 32'h14, 32'h0, 32'd5, 0, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'd8, 1, 1'b0, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0, 32'd8, 0, 1'b1, 32'h12345678, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0C, 32'h0, 32'd3, 0, 1'b1, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'hFFFFFFFC, 32'hA5A5A5A5, 32'h3FFFFFFF, 1, 1'b0, 32'h0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h3FFFFFFF, 0, 1'b1, 32'hA5A5A5A5, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 32'h22, 32'h55AA55AA, 32'd8, ALIGN ? 0 : 1, 1'b0, 32'h0, ALIGN};
    vecs[7] = '{1'b1, 1'b0, 32'h20, 32'h0, 32'd8, 0, 1'b1,
                ALIGN ? 32'h12345678 : 32'h55AA55AA, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 32'h17, 32'h0, 32'd5, 0, 1'b1, 32'hDEADBEEF, 1'b0};

    // Reset state while preloading memory
    preload(8'd5, 32'hDEADBEEF);
    preload(8'd3, 32'hCAFEF00D);
    preload(8'd16, 32'h0);
    preload(8'd17, 32'h77777777);
    #1;
    check("rst ready", {63'b0, bus.me_ready, bus.if_ready}, 65'd0);
    check("rst me_err", {64'b0, bus.me_err}, 65'd0);
    check("rst rdata", {1'b0, bus.if_rdata, bus.me_rdata}, 65'd0);
    check("rst mem_addr", {33'b0, bus.mem_addr}, 65'd0);
    check("rst edit_serial", bus.mem_edit_serial, 65'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i], i);
    end

    // Contention: both requests held, expect ME x4 then IF, twice
    exp_order = 10'b1000010000;  // bit k = 1 means IF owned pulse k
    order = '0;
    @(negedge clk);
    bus.me_req = 1'b1; bus.me_we = 1'b0; bus.me_addr = 32'h14;
    bus.if_req = 1'b1; bus.if_addr = 32'h0C;
    for (int k = 0; k < 10; k++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (!(bus.me_ready || bus.if_ready) && cyc < 20);
      check($sformatf("cont%0d both_ready", k), {64'b0, bus.me_ready & bus.if_ready}, 65'd0);
      order[k] = bus.if_ready;
      if (bus.if_ready) begin
        check($sformatf("cont%0d if_rdata", k), {33'b0, bus.if_rdata}, {33'b0, 32'hCAFEF00D});
      end else begin
        check($sformatf("cont%0d me_rdata", k), {33'b0, bus.me_rdata}, {33'b0, 32'hDEADBEEF});
        check($sformatf("cont%0d stall_if", k), {64'b0, bus.stall_if}, 65'd1);
      end
    end
    bus.me_req = 1'b0; bus.if_req = 1'b0;
    check("cont order", {55'b0, order}, {55'b0, exp_order});
    repeat (2) @(posedge clk);

    // Reset in the DONE cycle of a write to 0x40
    @(negedge clk);
    bus.me_req = 1'b1; bus.me_we = 1'b1; bus.me_addr = 32'h40; bus.me_wdata = 32'h0BADF00D;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!bus.me_ready && cyc < 20);
    check("rstdone ready_seen", {64'b0, bus.me_ready}, 65'd1);
    rst = 1'b1;
    bus.me_req = 1'b0; bus.me_we = 1'b0;
    @(posedge clk); #1;
    check("rstdone ready", {63'b0, bus.me_ready, bus.if_ready}, 65'd0);
    check("rstdone outs", {1'b0, bus.me_rdata, bus.mem_addr}, 65'd0);
    check("rstdone es", bus.mem_edit_serial, 65'd0);
    check("rstdone mem16", {33'b0, mem[16]}, {33'b0, 32'h0BADF00D});
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Reset on the grant edge of a write to 0x44
    @(negedge clk);
    p0 = we_pulses;
    rst = 1'b1;
    bus.me_req = 1'b1; bus.me_we = 1'b1; bus.me_addr = 32'h44; bus.me_wdata = 32'h11111111;
    @(posedge clk); #1;
    check("rstgrant es_we", {64'b0, bus.mem_edit_serial[64]}, 65'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.me_req = 1'b0; bus.me_we = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rstgrant pulses", 65'(we_pulses - p0), 65'd0);
    check("rstgrant mem17", {33'b0, mem[17]}, {33'b0, 32'h77777777});
    check("rstgrant ready", {63'b0, bus.me_ready, bus.if_ready}, 65'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single-port `MainMemory` array shared by the instruction-fetch (IF) and memory (ME) pipeline stages. It converts byte addresses to word addresses and builds the 65-bit edit serial `{we, word_addr, data}`. It grants one requester at a time, returns read data through registered outputs and raises per-stage stall signals. ME has priority over IF, with a starvation guard for IF. It sits between the IF/ME stage logic and the `MainMemory` instance.

## Interface
Parameters:
- `MEM_LATENCY`, 1: cycles from address presented to `mem_rdata` valid; legal range 1..15.
- `MAX_DATA_STREAK`, 4: consecutive ME grants allowed while IF is pending; legal range 1..15.

Ports:
- `Clock`  in  1  single clock; all state updates on posedge.
- `RESET`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_ready`.
- `if_addr`  in  32  fetch byte address.
- `if_rdata`  out  32  fetched word; valid while `if_ready`=1.
- `if_ready`  out  1  one-cycle completion pulse for IF.
- `me_req`  in  1  data request; held until `me_ready`.
- `me_we`  in  1  1 = write, 0 = read.
- `me_addr`  in  32  data byte address (`ALUResultM`).
- `me_wdata`  in  32  write data (`WriteDataM`).
- `me_rdata`  out  32  read word (`ReadDataM`); valid while `me_ready`=1.
- `me_ready`  out  1  one-cycle completion pulse for ME.
- `me_err`  out  1  misaligned-access flag; valid with `me_ready`.
- `mem_addr`  out  32  word address to `FETCH_ADDRESS`.
- `mem_edit_serial`  out  65  `{we, word_addr, wdata}` to `EDIT_SERIAL`.
- `mem_rdata`  in  32  `DATA` from `MainMemory`.
- `stall_if`, `stall_me`  out  1 each  `req & ~ready` for each stage; combinational.

## Operation
- FSM states:
  - `IDLE`: arbitrate on the current `me_req`/`if_req`.
  - `BUSY`: access in flight; down-counter `cnt` starts at MEM_LATENCY-1.
  - `DONE`: assert the owner's `ready` for exactly one cycle, then return to `IDLE`.
- Arbitration in `IDLE`:
  - Only `me_req`: grant ME.
  - Only `if_req`: grant IF.
  - Both: grant ME, unless `streak` == MAX_DATA_STREAK, in which case grant IF.
- `streak` counter:
  - Increments on each ME grant made while `if_req`=1, saturating at 15.
  - Clears on any IF grant, and in any `IDLE` cycle with `if_req`=0.
- On grant: latch `owner`, `we` (IF is always a read), `addr[31:2]` and `wdata` into holding registers. `mem_addr` = {2'b0, addr[31:2]}, driven from the holding register throughout `BUSY`.
- `mem_edit_serial[64]` (the write enable) is 1 only in the first `BUSY` cycle of a write and 0 in every other cycle. The address and data fields always mirror the holding registers.
- `BUSY`: when `cnt`=0, capture `mem_rdata` into the owner's rdata register and go to `DONE`; otherwise decrement `cnt`.
- Writes also capture `mem_rdata` (post-write read-back); ME ignores it.
- Requests are not sampled in `BUSY` or `DONE`. A requester that keeps `req` high after its `ready` pulse starts a new transaction at the next `IDLE` arbitration.
- The rdata registers of the non-owner hold their previous value.

## Timing
- Latency: `req` high at edge N in `IDLE` → `ready` high in cycle N+MEM_LATENCY+1. Turnaround is MEM_LATENCY+2 cycles per access.
- Reset values:
  - State `IDLE`; `cnt`, `streak`, `owner` all 0.
  - `if_ready`, `me_ready`, `me_err` = 0.
  - `if_rdata`, `me_rdata`, `mem_addr` = 0; `mem_edit_serial` = 65'b0.
- Reset mid-operation: the transaction is abandoned and no `ready` pulse is produced. A write whose enable cycle already passed stays committed; a write not yet issued is never issued.
- Requests rising in the same cycle that `RESET` deasserts are arbitrated at the next edge.
- `RESET` has priority over every other event in the same cycle.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A request with `me_addr[1:0]` ≠ 0 completes with normal timing and `me_err`=1 alongside `me_ready`.
  - Misaligned writes are suppressed: enable bit stays 0.
- Not defined: `addr[1:0]` is ignored (truncating divide by 4), and `me_err` is tied to 0.

## Structure
- Shared package `mem_pkg` holds:
  - FSM state enum `{IDLE, BUSY, DONE}`.
  - Owner encoding `OWN_IF`=0, `OWN_ME`=1.
  - `EDIT_SERIAL_W`=65.
  - Field offsets `ES_WE`=64, `ES_ADDR_LSB`=32.
- One sub-module, `mem_arb_pick`: combinational priority/starvation pick from `if_req`, `me_req` and `streak`. The FSM, counters and datapath stay in the top.

## Test plan
- ME read, MEM_LATENCY=1: preload word 5 = 0xDEADBEEF; `me_req`=1, `me_addr`=0x14 → `mem_addr`=5, `me_ready` pulses 2 cycles later with `me_rdata`=0xDEADBEEF, `stall_me`=1 until then.
- ME write: `me_we`=1, `me_addr`=0x20, `me_wdata`=0x12345678 → `mem_edit_serial`={1,32'd8,0x12345678} for exactly one cycle; a following read of 0x20 returns 0x12345678.
- Contention: `if_req` and `me_req` both held continuously, MAX_DATA_STREAK=4 → grant order ME,ME,ME,ME,IF,ME,ME,ME,ME,IF…; no `ready` pulse for both in the same cycle.
- Reset mid-write: assert `RESET` in the `DONE` cycle of a write to 0x40 → both `ready` outputs 0 the next cycle and all outputs at reset values; memory at word 16 holds the new data.
- Reset in the grant cycle: `RESET`=1 on the edge a write is granted → write enable never asserted and memory unchanged.
- Misaligned access, `MEM_ALIGN_CHECK_EN` defined: write to 0x22 → `me_ready`=1 with `me_err`=1, write enable never asserted. Same stimulus without the macro → word 8 written, `me_err`=0.
